cal_sequencer: RTL and testbench

//  Bus-slave front end that feeds the CAL calculator (ALU + multi-cycle MUL) from an instruction queue.

---
 rtl/cal_sequencer_if.sv | 10 +
 rtl/cal_sequencer.sv | 114 +++++++++++
 tb/tb_cal_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cal_sequencer_if.sv
// cal_sequencer_if: host register bus between a bus master and the cal_sequencer slave
interface cal_sequencer_if;
   logic        s_sel;
   logic        s_wr;
   logic [7:0]  s_addr;
   logic [31:0] s_din;
   logic [31:0] s_dout;
   modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
   modport slave (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/cal_sequencer.sv
// cal_sequencer: queues host instructions, issues them to CAL and queues the 64-bit results
module cal_sequencer #(
   parameter int IQ_DEPTH = 8,
   parameter int RQ_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   cal_sequencer_if.slave      bus,
   output logic [31:0]         cal_opcode,
   output logic [31:0]         cal_opstart,
   output logic [31:0]         cal_opclear,
   output logic [31:0]         cal_operandA,
   output logic [31:0]         cal_operandB,
   input  logic [63:0]         cal_re,
   input  logic [63:0]         cal_opdone,
   output logic                irq
);
   localparam int IAW = $clog2(IQ_DEPTH);
   localparam int RAW = $clog2(RQ_DEPTH);
   localparam int ICW = IAW + 1;
   localparam int RCW = RAW + 1;
   typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_t;
   state_t state, state_d;
   logic [31:0] opa, opb, h_a, h_b;
   logic [3:0] opc, h_op;
   logic inten, err_ovf, err_udf;
   logic [67:0] iq_mem [IQ_DEPTH];
   logic [63:0] rq_mem [RQ_DEPTH];
   logic [IAW-1:0] iq_wp, iq_rp;
   logic [RAW-1:0] rq_wp, rq_rp;
   logic [ICW-1:0] iq_cnt;
   logic [RCW-1:0] rq_cnt;
   logic wr, rd, flush, push_req, pop_req, iq_push, iq_pop, rq_push, rq_pop;
   logic iq_empty, iq_full, rq_empty, rq_full, done, busy;
   logic [63:0] res;
   logic unused_ok;
   assign unused_ok = ^cal_opdone[63:1];
   assign done = cal_opdone[0];
   assign busy = state != IDLE;
   assign iq_empty = iq_cnt == '0;
   assign iq_full = iq_cnt == ICW'(IQ_DEPTH);
   assign rq_empty = rq_cnt == '0;
   assign rq_full = rq_cnt == RCW'(RQ_DEPTH);
   assign wr = bus.s_sel && bus.s_wr;
   assign rd = bus.s_sel && !bus.s_wr;
   assign flush = wr && bus.s_addr == 8'h24 && bus.s_din[0];
   assign push_req = wr && bus.s_addr == 8'h0C && !flush;
   assign pop_req = wr && bus.s_addr == 8'h18;
   // A same-cycle FSM pop frees a slot, so a push into a full IQ is still legal then
   assign iq_pop = state == IDLE && !iq_empty && !rq_full && !flush;
   assign iq_push = push_req && (!iq_full || iq_pop);
   assign rq_push = state == ISSUE && done && !flush;
   assign rq_pop = pop_req && !rq_empty && !flush;
   assign res = rq_empty ? 64'd0 : rq_mem[rq_rp];
   assign cal_opstart = {31'd0, state == ISSUE};
   assign cal_opclear = {31'd0, state == CLEAR};
   assign cal_opcode = {28'd0, h_op};
   assign cal_operandA = h_a;
   assign cal_operandB = h_b;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = iq_pop ? ISSUE : IDLE;
         ISSUE:   state_d = (flush || done) ? CLEAR : ISSUE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.s_dout = '0;
      if (rd)
         case (bus.s_addr)
            8'h00:   bus.s_dout = opa;
            8'h04:   bus.s_dout = opb;
            8'h08:   bus.s_dout = {28'd0, opc};
            8'h10:   bus.s_dout = res[31:0];
            8'h14:   bus.s_dout = res[63:32];
            8'h1C:   bus.s_dout = {25'd0, err_udf, err_ovf, busy, rq_full, rq_empty, iq_full, iq_empty};
            8'h20:   bus.s_dout = {31'd0, inten};
            default: bus.s_dout = '0;
         endcase
   end
   always_ff @(posedge clk) begin
      if (iq_push) iq_mem[iq_wp] <= {opc, opa, opb};
      if (rq_push) rq_mem[rq_wp] <= cal_re;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         {opa, opb, opc, inten, err_ovf, err_udf} <= '0;
         {h_op, h_a, h_b, irq} <= '0;
         {iq_wp, iq_rp, iq_cnt, rq_wp, rq_rp, rq_cnt} <= '0;
      end else begin
         state <= state_d;
         if (wr && bus.s_addr == 8'h00) opa <= bus.s_din;
         if (wr && bus.s_addr == 8'h04) opb <= bus.s_din;
         if (wr && bus.s_addr == 8'h08) opc <= bus.s_din[3:0];
         if (wr && bus.s_addr == 8'h20) inten <= bus.s_din[0];
         err_ovf <= (push_req && !iq_push) || (err_ovf && !(wr && bus.s_addr == 8'h1C && bus.s_din[5]));
         err_udf <= (pop_req && rq_empty) || (err_udf && !(wr && bus.s_addr == 8'h1C && bus.s_din[6]));
         if (iq_pop) {h_op, h_a, h_b} <= iq_mem[iq_rp];
         irq <= inten && !rq_empty;
         if (flush) begin
            {iq_wp, iq_rp, iq_cnt, rq_wp, rq_rp, rq_cnt} <= '0;
         end else begin
            if (iq_push) iq_wp <= iq_wp + IAW'(1);
            if (iq_pop) iq_rp <= iq_rp + IAW'(1);
            if (rq_push) rq_wp <= rq_wp + RAW'(1);
            if (rq_pop) rq_rp <= rq_rp + RAW'(1);
            iq_cnt <= iq_cnt + ICW'(iq_push) - ICW'(iq_pop);
            rq_cnt <= rq_cnt + RCW'(rq_push) - RCW'(rq_pop);
         end
      end
   end
endmodule

// File: tb/tb_cal_sequencer.sv
// tb_cal_sequencer: scoreboard bench with a behavioural CAL (combinational ALU, 4-cycle MUL)
module tb_cal_sequencer;
   logic clk = 0, reset = 1;
   logic [31:0] cal_opcode, cal_opstart, cal_opclear, cal_operandA, cal_operandB;
   logic [63:0] cal_re, cal_opdone;
   logic irq;
   logic [2:0] mul_cnt = 0;
   int vectors = 0, errs = 0;
   int cyc = 0, n_issue = 0, n_start = 0, n_clear = 0, last_issue = -100, spacing_viol = 0, stable_viol = 0;
   logic prev_start = 0;
   logic [31:0] pa = 0, pb = 0, pc = 0;
   logic [63:0] sb [$];
   cal_sequencer_if bus ();
   cal_sequencer dut (.clk(clk), .reset(reset), .bus(bus), .cal_opcode(cal_opcode), .cal_opstart(cal_opstart),
      .cal_opclear(cal_opclear), .cal_operandA(cal_operandA), .cal_operandB(cal_operandB), .cal_re(cal_re),
      .cal_opdone(cal_opdone), .irq(irq));
   always #5 clk = ~clk;
   function automatic logic [63:0] cal_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'h0: return {32'd0, a} + {32'd0, b};
         4'h1: return {32'd0, a - b};
         4'h2: return {32'd0, a & b};
         4'hD: return {32'd0, a} * {32'd0, b};
         default: return 64'd0;
      endcase
   endfunction
   assign cal_re = cal_model(cal_opcode[3:0], cal_operandA, cal_operandB);
   assign cal_opdone = {63'd0, cal_opstart[0] && (cal_opcode[3:0] != 4'hD || mul_cnt == 3'd3)};
   always @(posedge clk) mul_cnt <= (cal_opstart[0] && !cal_opdone[0]) ? mul_cnt + 3'd1 : 3'd0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      prev_start <= cal_opstart[0];
      {pc, pa, pb} <= {cal_opcode, cal_operandA, cal_operandB};
      if (cal_opstart[0]) n_start <= n_start + 1;
      if (cal_opclear[0]) n_clear <= n_clear + 1;
      if (cal_opstart[0] && !prev_start) begin
         n_issue <= n_issue + 1;
         last_issue <= cyc;
         if (cyc - last_issue < 3) spacing_viol <= spacing_viol + 1;
      end
      if (cal_opstart[0] && prev_start && {cal_opcode, cal_operandA, cal_operandB} != {pc, pa, pb})
         stable_viol <= stable_viol + 1;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.s_sel = 1; bus.s_wr = 1; bus.s_addr = a; bus.s_din = d;
      @(posedge clk);
      #1 bus.s_sel = 0; bus.s_wr = 0;
   endtask
   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.s_sel = 1; bus.s_wr = 0; bus.s_addr = a;
      #1 d = bus.s_dout;
      @(posedge clk);
      #1 bus.s_sel = 0;
   endtask
   task automatic push_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit accept);
      bus_wr(8'h00, a);
      bus_wr(8'h04, b);
      bus_wr(8'h08, {28'hABCDEF0, op});
      bus_wr(8'h0C, 32'd0);
      if (accept) sb.push_back(cal_model(op, a, b));
   endtask
   task automatic read_result(output logic [63:0] r);
      logic [31:0] s, lo, hi;
      int n = 0;
      do begin bus_rd(8'h1C, s); n++; end while (s[2] && n < 100);
      check("rq_wait", {63'd0, s[2]}, 64'd0);
      bus_rd(8'h10, lo);
      bus_rd(8'h14, hi);
      r = {hi, lo};
      check("result", r, sb.size() != 0 ? sb.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0);
      bus_wr(8'h18, 32'd0);
   endtask
   task automatic wait_start();
      for (int i = 0; i < 50 && !cal_opstart[0]; i++) @(negedge clk);
      check("start_seen", {63'd0, cal_opstart[0]}, 64'd1);
   endtask
   initial begin
      logic [31:0] s;
      logic [63:0] r;
      int snap, snap2, snap3;
      bus.s_sel = 0; bus.s_wr = 0; bus.s_addr = 0; bus.s_din = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      bus_rd(8'h1C, s); check("rst_status", {32'd0, s}, 64'h5);
      bus_rd(8'h10, s); check("rst_reslo", {32'd0, s}, 64'd0);
      check("rst_opstart", {32'd0, cal_opstart}, 64'd0);
      check("rst_opcode", {32'd0, cal_opcode}, 64'd0);
      check("rst_irq", {63'd0, irq}, 64'd0);
      bus_wr(8'h08, 32'hFFFF_FFF3);
      bus_rd(8'h08, s); check("opcode_rb", {32'd0, s}, 64'h3);
      bus_wr(8'h20, 32'd1);
      // ADD
      snap = n_start; snap2 = n_clear;
      push_instr(4'h0, 32'd5, 32'd7, 1);
      repeat (6) @(negedge clk);
      check("add_irq", {63'd0, irq}, 64'd1);
      read_result(r);
      check("add_val", r, 64'd12);
      check("add_starts", 64'(n_start - snap), 64'd1);
      check("add_clears", 64'(n_clear - snap2), 64'd1);
      repeat (3) @(negedge clk);
      check("irq_drop", {63'd0, irq}, 64'd0);
      // MUL
      snap = n_start; snap2 = n_clear;
      push_instr(4'hD, 32'hFFFF_FFFF, 32'd2, 1);
      repeat (8) @(negedge clk);
      read_result(r);
      check("mul_val", r, 64'h1_FFFF_FFFE);
      check("mul_starts", 64'(n_start - snap), 64'd4);
      check("mul_clears", 64'(n_clear - snap2), 64'd1);
      // Overflow with stalled FSM
      for (int i = 0; i < 8; i++) push_instr(4'h2, 32'h100 + i, 32'hF0F, 1);
      for (int i = 0; i < 60; i++) begin bus_rd(8'h1C, s); if (s[3]) break; end
      check("rq_full", {63'd0, s[3]}, 64'd1);
      for (int i = 0; i < 9; i++) push_instr(4'h1, 32'h1000 * i, 32'd3 * i, i < 8);
      bus_rd(8'h1C, s); check("ovf_status", {32'd0, s}, 64'h2A);
      snap = n_issue;
      read_result(r);
      repeat (20) @(negedge clk);
      check("one_resume", 64'(n_issue - snap), 64'd1);
      for (int i = 0; i < 15; i++) read_result(r);
      bus_wr(8'h1C, 32'h20);
      bus_rd(8'h1C, s); check("ovf_cleared", {32'd0, s}, 64'h5);
      // Underflow
      bus_wr(8'h18, 32'd0);
      bus_rd(8'h1C, s); check("udf_status", {32'd0, s}, 64'h45);
      bus_rd(8'h10, s); check("udf_reslo", {32'd0, s}, 64'd0);
      bus_wr(8'h1C, 32'h40);
      bus_rd(8'h1C, s); check("udf_cleared", {32'd0, s}, 64'h5);
      push_instr(4'h0, 32'hFFFF_FFFF, 32'd1, 1);
      read_result(r);
      check("carry_val", r, 64'h1_0000_0000);
      // Mixed back-to-back
      snap = n_issue; snap2 = spacing_viol; snap3 = stable_viol;
      push_instr(4'h0, 32'd10, 32'd3, 1);
      push_instr(4'hD, 32'h1234_5678, 32'h10, 1);
      push_instr(4'h1, 32'd3, 32'd10, 1);
      for (int i = 0; i < 3; i++) read_result(r);
      check("mix_last", r, 64'h0000_0000_FFFF_FFF9);
      check("mix_issues", 64'(n_issue - snap), 64'd3);
      check("mix_spacing", 64'(spacing_viol - snap2), 64'd0);
      check("mix_stable", 64'(stable_viol - snap3), 64'd0);
      // Flush during MUL issue
      push_instr(4'hD, 32'd9, 32'd9, 0);
      wait_start();
      bus_wr(8'h24, 32'd1);
      repeat (10) @(negedge clk);
      bus_rd(8'h1C, s); check("flush_status", {32'd0, s}, 64'h5);
      // Reset during MUL issue with a pending result
      push_instr(4'h0, 32'd1, 32'd2, 1);
      repeat (6) @(negedge clk);
      push_instr(4'hD, 32'd3, 32'd4, 1);
      wait_start();
      check("pre_rst_irq", {63'd0, irq}, 64'd1);
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      sb.delete();
      @(negedge clk);
      check("rst_mid_opstart", {32'd0, cal_opstart}, 64'd0);
      check("rst_mid_irq", {63'd0, irq}, 64'd0);
      bus_rd(8'h1C, s); check("rst_mid_status", {32'd0, s}, 64'h5);
      snap = n_issue;
      repeat (20) @(negedge clk);
      bus_rd(8'h1C, s); check("rst_no_push", {32'd0, s}, 64'h5);
      check("rst_no_issue", 64'(n_issue - snap), 64'd0);
      check("stable_total", 64'(stable_viol), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
